// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// The request fields stay stable while bus_req is high; bus_rdata is valid with bus_ack.
interface mem_stage_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: runs a req/ack bus access, stalls the pipeline and returns
// aligned, extended load data. Define LSU_ADDR_ERR_EN to trap misaligned halfword/word accesses.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  memop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_err,
`ifdef LSU_ADDR_ERR_EN
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr,
`endif
    mem_stage_lsu_if.master bus
);

    typedef enum logic [2:0] {
        OpLb  = 3'd0,
        OpLbu = 3'd1,
        OpLh  = 3'd2,
        OpLhu = 3'd3,
        OpLw  = 3'd4,
        OpSb  = 3'd5,
        OpSh  = 3'd6,
        OpSw  = 3'd7
    } memop_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    memop_e      op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        op_store;
    logic        addr_fault;
    logic [3:0]  strb;

    assign op_store = (op_q == OpSb) || (op_q == OpSh) || (op_q == OpSw);

    function automatic logic [31:0] load_ext(memop_e op, logic [1:0] off, logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        lane_b = word[8*off +: 8];
        lane_h = word[16*off[1] +: 16];
        case (op)
            OpLb:    res = {{24{lane_b[7]}}, lane_b};
            OpLbu:   res = {24'h000000, lane_b};
            OpLh:    res = {{16{lane_h[15]}}, lane_h};
            OpLhu:   res = {16'h0000, lane_h};
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef LSU_ADDR_ERR_EN
    logic        adel_q, adel_d;
    logic        ades_q, ades_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        req_store;
    logic        req_misaligned;

    assign req_store = memop[2] && (memop[1:0] != 2'b00);

    always_comb begin
        case (memop_e'(memop))
            OpLh, OpLhu, OpSh: req_misaligned = addr[0];
            OpLw, OpSw:        req_misaligned = (addr[1:0] != 2'b00);
            default:           req_misaligned = 1'b0;
        endcase
    end

    assign addr_fault = adel_q || ades_q;
    assign adel       = (state_q == StDone) && adel_q;
    assign ades       = (state_q == StDone) && ades_q;
    assign badvaddr   = badvaddr_q;
`else
    assign addr_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef LSU_ADDR_ERR_EN
        adel_d     = adel_q;
        ades_d     = ades_q;
        badvaddr_d = badvaddr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = memop_e'(memop);
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StBusy;
`ifdef LSU_ADDR_ERR_EN
                    adel_d = 1'b0;
                    ades_d = 1'b0;
                    // A misaligned access never reaches the bus; it reports in DONE instead.
                    if (req_misaligned) begin
                        adel_d     = !req_store;
                        ades_d     = req_store;
                        badvaddr_d = addr;
                        state_d    = StDone;
                    end
`endif
                end
            end
            StBusy: begin
                if (bus.bus_ack) begin
                    if (!op_store) begin
                        rdata_d = load_ext(op_q, addr_q[1:0], bus.bus_rdata);
                    end
                    state_d = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpLb;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef LSU_ADDR_ERR_EN
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            adel_q     <= adel_d;
            ades_q     <= ades_d;
            badvaddr_q <= badvaddr_d;
        end
    end
`endif

    // Gated by rst so every output reads 0 while reset is asserted.
    assign stall       = rst && (((state_q == StIdle) && req_valid) || (state_q == StBusy));
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == StDone) && !err_q && !addr_fault;
    assign bus_err     = (state_q == StDone) && err_q;

    always_comb begin
        strb          = 4'b0000;
        bus.bus_wdata = '0;
        case (op_q)
            OpSb: begin
                strb          = 4'b0001 << addr_q[1:0];
                bus.bus_wdata = {4{wdata_q[7:0]}};
            end
            OpSh: begin
                strb          = addr_q[1] ? 4'b1100 : 4'b0011;
                bus.bus_wdata = {2{wdata_q[15:0]}};
            end
            OpSw: begin
                strb          = 4'b1111;
                bus.bus_wdata = wdata_q;
            end
            default: ;
        endcase
        bus.bus_req   = (state_q == StBusy);
        bus.bus_addr  = {addr_q[31:2], 2'b00};
        bus.bus_we    = bus.bus_req && op_store;
        bus.bus_wstrb = bus.bus_req ? strb : 4'b0000;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed table, reset-abort sequence, address-error
// cases when LSU_ADDR_ERR_EN is defined, and randomized accesses against a behavioural model.
module tb_mem_stage_lsu;
    localparam int unsigned T = 8;

    logic        clka = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  memop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_err;
`ifdef LSU_ADDR_ERR_EN
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;
`endif

    mem_stage_lsu_if bus_if ();

    mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clka        (clka),
        .rst         (rst),
        .req_valid   (req_valid),
        .memop       (memop),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .bus_err     (bus_err),
`ifdef LSU_ADDR_ERR_EN
        .adel        (adel),
        .ades        (ades),
        .badvaddr    (badvaddr),
`endif
        .bus         (bus_if)
    );

    always #5 clka = ~clka;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          ack_at;     // busy cycle (1-based) on which ack is given; 0 = never
        logic [31:0] exp_rdata;
        logic [31:0] exp_baddr;
        logic        exp_we;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        int          exp_req;
        int          exp_stall;
        logic        exp_valid;
        logic        exp_err;
        logic        exp_adel;
        logic        exp_ades;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_rdata = '0;
    vec_t        tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected behaviour from the access rules, using plain shifts and arithmetic.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev);
        int unsigned off = 32'(v.addr[1:0]);
        int unsigned b   = (v.rd >> (8 * off)) & 32'hFF;
        int unsigned h   = (v.rd >> (16 * 32'(v.addr[1]))) & 32'hFFFF;
        bit          st  = (v.op >= 3'd5);
        bit          acked = (v.ack_at >= 1) && (v.ack_at <= int'(T));
        bit          mis;
        v.exp_baddr = v.addr & ~32'd3;
        v.exp_we    = st;
        v.exp_strb  = 4'h0;
        v.exp_wdata = 32'h0;
        v.exp_adel  = 1'b0;
        v.exp_ades  = 1'b0;
        if (v.op == 3'd5) begin
            v.exp_strb  = 4'(1 << off);
            v.exp_wdata = 32'(v.wdata[7:0]) * 32'h01010101;
        end else if (v.op == 3'd6) begin
            v.exp_strb  = v.addr[1] ? 4'hC : 4'h3;
            v.exp_wdata = 32'(v.wdata[15:0]) * 32'h00010001;
        end else if (v.op == 3'd7) begin
            v.exp_strb  = 4'hF;
            v.exp_wdata = v.wdata;
        end
        v.exp_req   = acked ? v.ack_at : int'(T);
        v.exp_stall = v.exp_req + 1;
        v.exp_valid = acked;
        v.exp_err   = !acked;
        if (!acked)          v.exp_rdata = 32'h0;
        else if (st)         v.exp_rdata = prev;
        else if (v.op == 0)  v.exp_rdata = (b >= 128) ? b - 32'd256 : b;
        else if (v.op == 1)  v.exp_rdata = b;
        else if (v.op == 2)  v.exp_rdata = (h >= 32768) ? h - 32'd65536 : h;
        else if (v.op == 3)  v.exp_rdata = h;
        else                 v.exp_rdata = v.rd;
        mis = ((v.op == 2 || v.op == 3 || v.op == 6) && v.addr[0]) ||
              ((v.op == 4 || v.op == 7) && off != 0);
`ifdef LSU_ADDR_ERR_EN
        if (mis) begin
            v.exp_req   = 0;
            v.exp_stall = 1;
            v.exp_valid = 1'b0;
            v.exp_err   = 1'b0;
            v.exp_adel  = !st;
            v.exp_ades  = st;
            v.exp_rdata = prev;
        end
`else
        if (mis) v.exp_adel = 1'b0;
`endif
        return v;
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        int          k = 0;
        int          req_n = 0, stall_n = 0, valid_n = 0, err_n = 0, adel_n = 0, ades_n = 0;
        logic        done = 1'b0, moved = 1'b0, fault = 1'b0, we0 = 1'b0;
        logic [3:0]  s0 = '0;
        logic [31:0] a0 = '0, w0 = '0, rd_done = '0, bv_done = '0;
        @(negedge clka);
        req_valid = 1'b1;
        memop     = v.op;
        addr      = v.addr;
        wdata     = v.wdata;
        while (!done && k < 40) begin
            if (k > 0) @(negedge clka);
            #1;
            k++;
            if (stall) stall_n++;
            if (bus_if.bus_req) begin
                req_n++;
                if (req_n == 1) begin
                    {we0, s0, a0, w0} = {bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_addr,
                                         bus_if.bus_wdata};
                end else if ({we0, s0, a0, w0} !== {bus_if.bus_we, bus_if.bus_wstrb,
                                                   bus_if.bus_addr, bus_if.bus_wdata}) begin
                    moved = 1'b1;
                end
            end
            if (rdata_valid) valid_n++;
            if (bus_err) err_n++;
`ifdef LSU_ADDR_ERR_EN
            if (adel) adel_n++;
            if (ades) ades_n++;
            fault   = adel || ades;
            bv_done = badvaddr;
`endif
            if (rdata_valid || bus_err || fault) begin
                done    = 1'b1;
                rd_done = rdata;
            end
            bus_if.bus_ack   = bus_if.bus_req && (req_n == v.ack_at);
            bus_if.bus_rdata = bus_if.bus_ack ? v.rd : $urandom();
        end
        bus_if.bus_ack = 1'b0;
        chk({tag, ".completes"}, 32'(done), 32'd1);
        if (done) begin
            chk({tag, ".req_cycles"}, req_n, v.exp_req);
            chk({tag, ".stall_cycles"}, stall_n, v.exp_stall);
            chk({tag, ".rdata_valid"}, valid_n, 32'(v.exp_valid));
            chk({tag, ".bus_err"}, err_n, 32'(v.exp_err));
            chk({tag, ".rdata"}, rd_done, v.exp_rdata);
            chk({tag, ".adel"}, adel_n, 32'(v.exp_adel));
            chk({tag, ".ades"}, ades_n, 32'(v.exp_ades));
            if (v.exp_adel || v.exp_ades) chk({tag, ".badvaddr"}, bv_done, v.addr);
            if (v.exp_req > 0) begin
                chk({tag, ".stable"}, 32'(moved), 32'd0);
                chk({tag, ".bus_addr"}, a0, v.exp_baddr);
                chk({tag, ".bus_we"}, 32'(we0), 32'(v.exp_we));
                chk({tag, ".bus_wstrb"}, 32'(s0), 32'(v.exp_strb));
                if (v.exp_we) chk({tag, ".bus_wdata"}, w0, v.exp_wdata);
            end
        end
        // DONE has just seen req_valid still high; it must not start a second access.
        @(negedge clka);
        req_valid = 1'b0;
        #1;
        chk({tag, ".no_reissue"}, 32'(bus_if.bus_req), 32'd0);
        chk({tag, ".single_pulse"}, 32'(rdata_valid || bus_err), 32'd0);
        model_rdata = v.exp_rdata;
    endtask

    initial begin
        vec_t v;
        int   quiet;

        //            op     addr       wdata         rd            ack rdata         baddr
        //            we  strb  wdata         req stall valid err adel ades
        tbl[0]  = '{3'd4, 32'h100, 32'h0,        32'hDEADBEEF, 3, 32'hDEADBEEF, 32'h100,
                    1'b0, 4'h0, 32'h0,        3, 4, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'd0, 32'h203, 32'h0,        32'h80ABCD12, 1, 32'hFFFFFF80, 32'h200,
                    1'b0, 4'h0, 32'h0,        1, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'd1, 32'h203, 32'h0,        32'h80ABCD12, 2, 32'h00000080, 32'h200,
                    1'b0, 4'h0, 32'h0,        2, 3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd3, 32'h202, 32'h0,        32'h80ABCD12, 1, 32'h000080AB, 32'h200,
                    1'b0, 4'h0, 32'h0,        1, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'd6, 32'h302, 32'h1234ABCD, 32'h0,        1, 32'h000080AB, 32'h300,
                    1'b1, 4'hC, 32'hABCDABCD, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{3'd5, 32'h301, 32'h1234ABCD, 32'h0,        2, 32'h000080AB, 32'h300,
                    1'b1, 4'h2, 32'hCDCDCDCD, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{3'd4, 32'h400, 32'h0,        32'h55555555, 0, 32'h00000000, 32'h400,
                    1'b0, 4'h0, 32'h0,        8, 9, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{3'd4, 32'h404, 32'h0,        32'h13579BDF, 8, 32'h13579BDF, 32'h404,
                    1'b0, 4'h0, 32'h0,        8, 9, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{3'd2, 32'h002, 32'h0,        32'hFEDC0000, 1, 32'hFFFFFEDC, 32'h000,
                    1'b0, 4'h0, 32'h0,        1, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{3'd7, 32'h010, 32'hCAFEF00D, 32'h0,        4, 32'hFFFFFEDC, 32'h010,
                    1'b1, 4'hF, 32'hCAFEF00D, 4, 5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'd0, 32'h000, 32'h0,        32'h0000007F, 1, 32'h0000007F, 32'h000,
                    1'b0, 4'h0, 32'h0,        1, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{3'd2, 32'h000, 32'h0,        32'h00008001, 3, 32'hFFFF8001, 32'h000,
                    1'b0, 4'h0, 32'h0,        3, 4, 1'b1, 1'b0, 1'b0, 1'b0};

        rst              = 1'b0;
        req_valid        = 1'b0;
        memop            = 3'd0;
        addr             = '0;
        wdata            = '0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
        repeat (3) @(negedge clka);
        #1;
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("reset.rdata_valid", 32'(rdata_valid), 32'd0);
        chk("reset.bus_err", 32'(bus_err), 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        chk("reset.bus_fields", {bus_if.bus_addr[27:0], bus_if.bus_wstrb},
            32'(bus_if.bus_we) | 32'(|bus_if.bus_wdata));
        @(negedge clka);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Reset asserted on the second busy cycle of a load aborts it silently.
        @(negedge clka);
        req_valid = 1'b1;
        memop     = 3'd4;
        addr      = 32'h500;
        @(negedge clka);
        #1;
        chk("abort.busy1", 32'(bus_if.bus_req), 32'd1);
        @(negedge clka);
        #1;
        chk("abort.busy2", 32'(bus_if.bus_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort.bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("abort.stall", 32'(stall), 32'd0);
        chk("abort.rdata", rdata, 32'd0);
        @(negedge clka);
        req_valid = 1'b0;
        rst       = 1'b1;
        quiet     = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clka);
            #1;
            if (bus_if.bus_req || rdata_valid || bus_err) quiet++;
        end
        chk("abort.quiet_after_release", quiet, 0);
        model_rdata = '0;
        v = '{3'd4, 32'h600, 32'h0, 32'h0BADF00D, 2, 32'h0, 32'h0,
              1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_vec("after_abort", model(v, model_rdata));

`ifdef LSU_ADDR_ERR_EN
        v = '{3'd4, 32'h102, 32'h0, 32'hFFFFFFFF, 1, model_rdata, 32'h0,
              1'b0, 4'h0, 32'h0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        run_vec("adel_lw", v);
        v = '{3'd6, 32'h305, 32'h1234ABCD, 32'h0, 1, model_rdata, 32'h0,
              1'b1, 4'h0, 32'h0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_vec("ades_sh", v);
`endif

        for (int i = 0; i < 60; i++) begin
            v.op     = 3'($urandom_range(0, 7));
            v.addr   = $urandom();
            v.wdata  = $urandom();
            v.rd     = $urandom();
            v.ack_at = $urandom_range(0, T + 2);
            run_vec($sformatf("rnd%0d", i), model(v, model_rdata));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
